// File: rtl/ioreg_master_pkg.sv
// Shared types for the IOREG bus master: FSM states, queued command format and bus widths.
package ioreg_master_pkg;

  localparam int IOREG_ADDR_W = 16;
  localparam int IOREG_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_TURN  = 3'd2,
    ST_READ1 = 3'd3,
    ST_READ2 = 3'd4
  } state_e;

  typedef struct packed {
    logic                    write;
    logic [IOREG_ADDR_W-1:0] addr;
    logic [IOREG_DATA_W-1:0] data;
  } cmd_t;

  function automatic cmd_t pack_cmd(input logic                    write,
                                    input logic [IOREG_ADDR_W-1:0] addr,
                                    input logic [IOREG_DATA_W-1:0] data);
    cmd_t c;
    c.write = write;
    c.addr  = addr;
    c.data  = data;
    return c;
  endfunction

endpackage

// File: rtl/ioreg_bus_master_if.sv
// Client command/response handshake and IOREG bus strobes of the bus master, bundled with modports.
interface ioreg_bus_master_if;
  import ioreg_master_pkg::*;

  logic                    I_CMD_VALID;
  logic                    O_CMD_READY;
  logic                    I_CMD_WRITE;
  logic [IOREG_ADDR_W-1:0] I_CMD_ADDR;
  logic [IOREG_DATA_W-1:0] I_CMD_DATA;
  logic                    I_BUS_GRANT;
  logic                    O_BUSY;
  logic                    O_RSP_VALID;
  logic [IOREG_DATA_W-1:0] O_RSP_DATA;
  logic [IOREG_ADDR_W-1:0] O_IOREG_ADDR;
  logic                    O_IOREG_WE_L;
  logic                    O_IOREG_RE_L;

  modport master (
    input  I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_DATA, I_BUS_GRANT,
    output O_CMD_READY, O_BUSY, O_RSP_VALID, O_RSP_DATA,
    output O_IOREG_ADDR, O_IOREG_WE_L, O_IOREG_RE_L
  );

  modport slave (
    output I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_DATA, I_BUS_GRANT,
    input  O_CMD_READY, O_BUSY, O_RSP_VALID, O_RSP_DATA,
    input  O_IOREG_ADDR, O_IOREG_WE_L, O_IOREG_RE_L
  );

endinterface

// File: rtl/ioreg_cmd_fifo.sv
// Synchronous command FIFO; full/empty are registered so the ready flag derived from them is glitch-free.
module ioreg_cmd_fifo
  import ioreg_master_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = cmd_t
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  T                           i_din,
  input  logic                       i_pop,
  output T                           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_cnt_nxt;

  // A full FIFO refuses pushes even when it pops in the same cycle.
  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop  & ~r_empty;

  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/ioreg_bus_master.sv
// IOREG bus initiator: replays queued client commands as write/read bus cycles while granted.
// Define IOREG_MASTER_READ_EN to build bus read cycles; otherwise read commands are dropped.
module ioreg_bus_master
  import ioreg_master_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    I_CLK,
  input  logic                    I_RESET,
  ioreg_bus_master_if.master      bus,
  inout  wire  [IOREG_DATA_W-1:0] IO_IOREG_DATA
);

  state_e                  r_state;
  logic                    r_we_l;
  logic                    r_re_l;
  logic [IOREG_ADDR_W-1:0] r_addr;
  logic [IOREG_DATA_W-1:0] r_wdata;

  cmd_t                    w_push_cmd;
  cmd_t                    w_head;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [$clog2(DEPTH+1)-1:0] w_fifo_count;
  logic                    w_data_oe;
  logic                    w_unused_count;

  assign w_push_cmd = pack_cmd(bus.I_CMD_WRITE, bus.I_CMD_ADDR, bus.I_CMD_DATA);
  assign w_push     = bus.I_CMD_VALID & ~w_fifo_full;

  // TURN doubles as an issue slot so back-to-back writes run every 2 cycles.
  assign w_pop = ((r_state == ST_IDLE) || (r_state == ST_TURN)) &
                 ~w_fifo_empty & bus.I_BUS_GRANT;

  ioreg_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .i_clk   (I_CLK),
    .i_rst   (I_RESET),
    .i_push  (w_push),
    .i_din   (w_push_cmd),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_unused_count = ^w_fifo_count;

`ifdef IOREG_MASTER_READ_EN
  logic                    r_rsp_valid;
  logic [IOREG_DATA_W-1:0] r_rsp_data;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_state     <= ST_IDLE;
      r_we_l      <= 1'b1;
      r_re_l      <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_TURN: begin
          r_we_l  <= 1'b1;
          r_re_l  <= 1'b1;
          r_state <= ST_IDLE;
          if (w_pop) begin
            r_addr <= w_head.addr;
            if (w_head.write) begin
              r_state <= ST_WRITE;
              r_we_l  <= 1'b0;
              r_wdata <= w_head.data;
            end else begin
              r_state <= ST_READ1;
              r_re_l  <= 1'b0;
            end
          end
        end
        ST_WRITE: begin
          r_we_l  <= 1'b1;
          r_state <= ST_TURN;
        end
        ST_READ1: begin
          r_state <= ST_READ2;
        end
        ST_READ2: begin
          r_re_l      <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= IO_IOREG_DATA;
          r_state     <= ST_TURN;
        end
        default: begin
          r_we_l  <= 1'b1;
          r_re_l  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.O_RSP_VALID = r_rsp_valid;
  assign bus.O_RSP_DATA  = r_rsp_data;
`else
  logic w_unused_io;

  // Reads are popped and dropped without leaving IDLE/TURN.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_state <= ST_IDLE;
      r_we_l  <= 1'b1;
      r_re_l  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_re_l <= 1'b1;
      case (r_state)
        ST_IDLE, ST_TURN: begin
          r_we_l  <= 1'b1;
          r_state <= ST_IDLE;
          if (w_pop && w_head.write) begin
            r_state <= ST_WRITE;
            r_we_l  <= 1'b0;
            r_addr  <= w_head.addr;
            r_wdata <= w_head.data;
          end
        end
        ST_WRITE: begin
          r_we_l  <= 1'b1;
          r_state <= ST_TURN;
        end
        default: begin
          r_we_l  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_unused_io     = ^IO_IOREG_DATA;
  assign bus.O_RSP_VALID = 1'b0;
  assign bus.O_RSP_DATA  = '0;
`endif

  assign w_data_oe     = (r_state == ST_WRITE);
  assign IO_IOREG_DATA = w_data_oe ? r_wdata : {IOREG_DATA_W{1'bz}};

  assign bus.O_CMD_READY  = ~w_fifo_full;
  assign bus.O_BUSY       = (r_state != ST_IDLE);
  assign bus.O_IOREG_ADDR = r_addr;
  assign bus.O_IOREG_WE_L = r_we_l;
  assign bus.O_IOREG_RE_L = r_re_l;

endmodule
